tick_scheduler: RTL and testbench
=================================

Name: tick_scheduler

Overview:
- Central timing controller for the game design.
- Generates one-cycle clock-enable ticks for the display refresh, LED, snake-step and slow (1 s-class) domains from the single system clock.
- Adds a run/pause/stop state machine and a runtime-selectable snake speed, so downstream blocks run on clk with enables rather than derived clocks.

Parameters:
- CNT_W, 27, width of every divide counter.
- SEG_DIV, 131072, seg_tick period in clk cycles (min 2).
- LED_DIV, 33554432, led_tick period in clk cycles (min 2).
- SNAKE_BASE, 67108864, snake_tick period at speed 0; must be a multiple of 8.
- SLOW_DIV, 134217728, slow_tick period in clk cycles (min 2).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request: IDLE->RUN, or PAUSE->RUN
- pause  in  1  one-cycle request: RUN->PAUSE
- stop  in  1  one-cycle request: any state->IDLE
- speed  in  2  requested snake speed, 0 slowest, 3 fastest
- speed_we  in  1  latch speed into the pending register
- seg_tick  out  1  display-scan enable pulse
- led_tick  out  1  LED enable pulse
- snake_tick  out  1  snake-step enable pulse
- slow_tick  out  1  slow enable pulse
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE
- speed_cur  out  2  speed currently in effect
- speed_pend  out  1  a written speed is waiting to be applied
- step_cnt  out  16  number of snake_ticks since leaving IDLE

Behaviour:
- Reset (async, reset=0):
  - State IDLE, all counters 0, all ticks 0, speed_cur 0, speed_pend 0, step_cnt 0.
- Tick rule, all four channels:
  - Each enabled edge increments the counter.
  - At count DIV-1 the counter wraps to 0 on that edge and the registered tick goes high for exactly the following cycle.
  - First tick is high in the cycle after the DIV-th enabled edge.
  - Ticks are never high for 2 consecutive cycles unless DIV=1, which is illegal.
- Channel enables:
  - seg and slow counters free-run in every state from the first edge after reset release.
  - led and snake counters count only in RUN, hold their value in PAUSE, and are held at 0 in IDLE.
  - The snake divisor is SNAKE_BASE >> speed_cur (speed 3 = SNAKE_BASE/8).
- FSM:
  - IDLE -start-> RUN.
  - RUN -pause-> PAUSE.
  - PAUSE -start-> RUN; led and snake resume from their held counts.
  - Any state -stop-> IDLE; led/snake counters and step_cnt clear on that edge.
- Request priority: stop > pause > start when asserted together. Requests that are invalid in the current state are ignored (no error, no queuing).
- Transition timing: a transition takes effect on the edge where the request is sampled; the new state counts from the next edge.
- Speed update:
  - speed_we loads speed into the pending register and sets speed_pend on the same edge.
  - A later speed_we overwrites the pending value.
  - In RUN, the pending value is applied on the edge the snake counter wraps; the new period governs the next interval and never truncates the current one.
  - In IDLE or PAUSE, it is applied on the next edge. In PAUSE, that edge also clears the snake counter to 0.
  - speed_pend clears on the apply edge.
  - speed_we coinciding with an apply edge: the new value becomes pending and the old pending value is applied.
- step_cnt:
  - Increments in the cycle snake_tick is high (registered, +1 visible the following cycle).
  - Wraps 0xFFFF->0 silently.
  - Held in PAUSE, cleared in IDLE.
- stop on the same edge as a snake wrap: stop wins, no snake_tick is issued and step_cnt clears.
- Reset mid-operation: immediate return to reset values regardless of state or pending speed.

Test Plan:
All scenarios use SEG_DIV=4, LED_DIV=6, SNAKE_BASE=16, SLOW_DIV=32.
- Release reset, idle 40 cycles -> seg_tick high at cycles 4,8,12..., slow_tick at 32; led_tick/snake_tick never high; state=00.
- start at cycle 0, run 50 cycles -> snake_tick at cycles 16,32,48; led_tick every 6; step_cnt=3; state=01.
- RUN, pause after snake count 10, hold 20 cycles, start -> no snake/led ticks while paused; next snake_tick 6 cycles after resume; seg_tick uninterrupted.
- RUN speed 0, speed=3 with speed_we at count 5 -> speed_pend=1 until cycle 16 wrap; snake_tick then every 2 cycles; speed_cur=3.
- start, pause, stop asserted on the same edge in RUN -> state=00, step_cnt=0, counters 0.
- Assert reset at snake count 9 with speed_pend=1 -> all outputs return to reset values asynchronously; pending speed discarded.

Source files
------------

// File: rtl/tick_scheduler.sv
// Central timing controller: one-cycle enable ticks for the display, LED, snake-step and
// slow domains, plus a run/pause/stop FSM and a deferred snake speed update.
module tick_scheduler #(
   parameter int unsigned CNT_W      = 27,
   parameter int unsigned SEG_DIV    = 131072,
   parameter int unsigned LED_DIV    = 33554432,
   parameter int unsigned SNAKE_BASE = 67108864,
   parameter int unsigned SLOW_DIV   = 134217728
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        pause,
   input  logic        stop,
   input  logic [1:0]  speed,
   input  logic        speed_we,
   output logic        seg_tick,
   output logic        led_tick,
   output logic        snake_tick,
   output logic        slow_tick,
   output logic [1:0]  state,
   output logic [1:0]  speed_cur,
   output logic        speed_pend,
   output logic [15:0] step_cnt
);

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StRun   = 2'b01,
      StPause = 2'b10
   } state_e;

   localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
   localparam logic [CNT_W-1:0] SegLast   = CNT_W'(SEG_DIV - 1);
   localparam logic [CNT_W-1:0] LedLast   = CNT_W'(LED_DIV - 1);
   localparam logic [CNT_W-1:0] SlowLast  = CNT_W'(SLOW_DIV - 1);
   localparam logic [CNT_W-1:0] SnakeBase = CNT_W'(SNAKE_BASE);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] seg_cnt_q, seg_cnt_d;
   logic [CNT_W-1:0] slow_cnt_q, slow_cnt_d;
   logic [CNT_W-1:0] led_cnt_q, led_cnt_d;
   logic [CNT_W-1:0] snake_cnt_q, snake_cnt_d;
   logic [CNT_W-1:0] snake_last;
   logic             seg_tick_q, led_tick_q, snake_tick_q, slow_tick_q;
   logic             seg_wrap, slow_wrap, led_wrap, snake_wrap;
   logic             run_en, clr, apply;
   logic [1:0]       speed_cur_q, speed_cur_d;
   logic [1:0]       speed_nxt_q, speed_nxt_d;
   logic             speed_pend_q, speed_pend_d;
   logic [15:0]      step_cnt_q, step_cnt_d;

   // Next state: stop beats everything; pause only acts in RUN, start in IDLE/PAUSE.
   always_comb begin
      state_d = state_q;
      if (stop) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (pause) state_d = StPause;
            StPause: if (start) state_d = StRun;
            default: state_d = StIdle;
         endcase
      end
   end

   // Counter, tick, speed and step-count next-state logic.
   always_comb begin
      // Enables follow the state held during this cycle; a stop edge clears instead of counting.
      run_en     = (state_q == StRun) && !stop;
      clr        = stop || (state_q == StIdle);
      snake_last = (SnakeBase >> speed_cur_q) - CntOne;

      seg_wrap   = (seg_cnt_q == SegLast);
      slow_wrap  = (slow_cnt_q == SlowLast);
      led_wrap   = run_en && (led_cnt_q == LedLast);
      snake_wrap = run_en && (snake_cnt_q == snake_last);

      // Pending speed waits for a wrap in RUN so the running interval is never truncated.
      apply = speed_pend_q && ((state_q == StRun) ? snake_wrap : 1'b1);

      seg_cnt_d  = seg_wrap ? '0 : seg_cnt_q + CntOne;
      slow_cnt_d = slow_wrap ? '0 : slow_cnt_q + CntOne;

      led_cnt_d = led_cnt_q;
      if (clr)         led_cnt_d = '0;
      else if (run_en) led_cnt_d = led_wrap ? '0 : led_cnt_q + CntOne;

      snake_cnt_d = snake_cnt_q;
      if (clr)                             snake_cnt_d = '0;
      else if (apply && state_q == StPause) snake_cnt_d = '0;
      else if (run_en)                      snake_cnt_d = snake_wrap ? '0 : snake_cnt_q + CntOne;

      speed_cur_d  = apply ? speed_nxt_q : speed_cur_q;
      speed_nxt_d  = speed_we ? speed : speed_nxt_q;
      speed_pend_d = speed_we || (speed_pend_q && !apply);

      step_cnt_d = step_cnt_q;
      if (clr)               step_cnt_d = '0;
      else if (snake_tick_q) step_cnt_d = step_cnt_q + 16'd1;
   end

   // State register bank with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         seg_cnt_q    <= '0;
         slow_cnt_q   <= '0;
         led_cnt_q    <= '0;
         snake_cnt_q  <= '0;
         seg_tick_q   <= 1'b0;
         slow_tick_q  <= 1'b0;
         led_tick_q   <= 1'b0;
         snake_tick_q <= 1'b0;
         speed_cur_q  <= 2'd0;
         speed_nxt_q  <= 2'd0;
         speed_pend_q <= 1'b0;
         step_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         seg_cnt_q    <= seg_cnt_d;
         slow_cnt_q   <= slow_cnt_d;
         led_cnt_q    <= led_cnt_d;
         snake_cnt_q  <= snake_cnt_d;
         seg_tick_q   <= seg_wrap;
         slow_tick_q  <= slow_wrap;
         led_tick_q   <= led_wrap;
         snake_tick_q <= snake_wrap;
         speed_cur_q  <= speed_cur_d;
         speed_nxt_q  <= speed_nxt_d;
         speed_pend_q <= speed_pend_d;
         step_cnt_q   <= step_cnt_d;
      end
   end

   assign seg_tick   = seg_tick_q;
   assign led_tick   = led_tick_q;
   assign snake_tick = snake_tick_q;
   assign slow_tick  = slow_tick_q;
   assign state      = state_q;
   assign speed_cur  = speed_cur_q;
   assign speed_pend = speed_pend_q;
   assign step_cnt   = step_cnt_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: directed scenarios plus random requests,
// compared every cycle against an event-count reference model.
module tb_tick_scheduler;

   localparam int SegDiv    = 4;
   localparam int LedDiv    = 6;
   localparam int SnakeBase = 16;
   localparam int SlowDiv   = 32;
   localparam int MIdle     = 0;
   localparam int MRun      = 1;
   localparam int MPause    = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, pause, stop, speed_we;
   logic [1:0]  speed;
   logic        seg_tick, led_tick, snake_tick, slow_tick;
   logic [1:0]  state, speed_cur;
   logic        speed_pend;
   logic [15:0] step_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: event counts since the last clear, not counter encodings.
   int m_state, m_seg_n, m_slow_n, m_led_n, m_snk_n, m_speed, m_pend_val, m_step;
   bit m_pend, m_seg_t, m_slow_t, m_led_t, m_snk_t;

   tick_scheduler #(
      .CNT_W      (8),
      .SEG_DIV    (SegDiv),
      .LED_DIV    (LedDiv),
      .SNAKE_BASE (SnakeBase),
      .SLOW_DIV   (SlowDiv)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .pause      (pause),
      .stop       (stop),
      .speed      (speed),
      .speed_we   (speed_we),
      .seg_tick   (seg_tick),
      .led_tick   (led_tick),
      .snake_tick (snake_tick),
      .slow_tick  (slow_tick),
      .state      (state),
      .speed_cur  (speed_cur),
      .speed_pend (speed_pend),
      .step_cnt   (step_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state = MIdle; m_seg_n = 0; m_slow_n = 0; m_led_n = 0; m_snk_n = 0;
      m_speed = 0; m_pend_val = 0; m_step = 0; m_pend = 0;
      m_seg_t = 0; m_slow_t = 0; m_led_t = 0; m_snk_t = 0;
   endtask

   task automatic model_edge(input bit st, input bit pa, input bit sp, input int spd,
                             input bit we);
      int period;
      bit wrapped, apply, prev_snk;
      period   = SnakeBase >> m_speed;
      wrapped  = 0;
      prev_snk = m_snk_t;
      m_seg_n++;  m_seg_t  = (m_seg_n % SegDiv == 0);
      m_slow_n++; m_slow_t = (m_slow_n % SlowDiv == 0);
      if (m_state == MRun && !sp) begin
         m_led_n++;
         m_led_t = (m_led_n % LedDiv == 0);
         m_snk_n++;
         if (m_snk_n == period) begin
            wrapped = 1;
            m_snk_n = 0;
         end
      end else begin
         m_led_t = 0;
         if (sp || m_state == MIdle) begin
            m_led_n = 0;
            m_snk_n = 0;
         end
      end
      m_snk_t = wrapped;
      apply = m_pend && (m_state == MRun ? wrapped : 1'b1);
      if (apply) begin
         m_speed = m_pend_val;
         if (m_state == MPause) m_snk_n = 0;
      end
      if (we) begin
         m_pend_val = spd;
         m_pend     = 1;
      end else if (apply) begin
         m_pend = 0;
      end
      if (sp || m_state == MIdle) m_step = 0;
      else if (prev_snk)          m_step = (m_step + 1) % 65536;
      if (sp)                              m_state = MIdle;
      else if (m_state == MIdle && st)     m_state = MRun;
      else if (m_state == MRun && pa)      m_state = MPause;
      else if (m_state == MPause && st)    m_state = MRun;
   endtask

   task automatic compare_all();
      check("seg_tick",   32'(seg_tick),   32'(m_seg_t));
      check("slow_tick",  32'(slow_tick),  32'(m_slow_t));
      check("led_tick",   32'(led_tick),   32'(m_led_t));
      check("snake_tick", 32'(snake_tick), 32'(m_snk_t));
      check("state",      32'(state),      32'(m_state));
      check("speed_cur",  32'(speed_cur),  32'(m_speed));
      check("speed_pend", 32'(speed_pend), 32'(m_pend));
      check("step_cnt",   32'(step_cnt),   32'(m_step));
   endtask

   // Present requests for one edge, update the model on that edge, check 1 time unit later.
   task automatic tick_cycle(input bit st, input bit pa, input bit sp, input int spd,
                             input bit we);
      start = st; pause = pa; stop = sp; speed = 2'(spd); speed_we = we;
      @(posedge clk);
      model_edge(st, pa, sp, spd, we);
      #1;
      start = 0; pause = 0; stop = 0; speed_we = 0;
      compare_all();
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) tick_cycle(0, 0, 0, 0, 0);
   endtask

   // Asynchronous reset between edges; outputs must clear without a clock edge.
   task automatic async_reset();
      #2;
      reset = 0;
      model_reset();
      #1;
      compare_all();
      reset = 1;
   endtask

   initial begin
      reset = 0; start = 0; pause = 0; stop = 0; speed = 0; speed_we = 0;
      model_reset();
      #12;
      compare_all();
      reset = 1;

      // Idle: only seg/slow tick.
      idle_cycles(40);
      check("idle_state", 32'(state), 32'd0);

      // Run 50 cycles from start: snake ticks at 16, 32, 48.
      tick_cycle(1, 0, 0, 0, 0);
      idle_cycles(50);
      check("run_step3", 32'(step_cnt), 32'd3);

      // Pause mid-interval, hold, resume.
      tick_cycle(0, 0, 1, 0, 0);
      tick_cycle(1, 0, 0, 0, 0);
      idle_cycles(10);
      tick_cycle(0, 1, 0, 0, 0);
      idle_cycles(20);
      tick_cycle(1, 0, 0, 0, 0);
      idle_cycles(12);

      // Speed change in RUN deferred to the wrap.
      tick_cycle(0, 0, 1, 0, 0);
      tick_cycle(1, 0, 0, 0, 0);
      idle_cycles(5);
      tick_cycle(0, 0, 0, 3, 1);
      check("spd_pend_set", 32'(speed_pend), 32'd1);
      idle_cycles(20);
      check("spd_cur3", 32'(speed_cur), 32'd3);

      // Speed change while paused applies next edge.
      tick_cycle(0, 1, 0, 0, 0);
      tick_cycle(0, 0, 0, 1, 1);
      idle_cycles(3);
      tick_cycle(1, 0, 0, 0, 0);
      idle_cycles(20);

      // start+pause+stop together in RUN.
      tick_cycle(1, 1, 1, 0, 0);
      check("all3_state", 32'(state), 32'd0);
      check("all3_step",  32'(step_cnt), 32'd0);
      idle_cycles(4);

      // Async reset with a pending speed.
      tick_cycle(1, 0, 0, 0, 0);
      idle_cycles(9);
      tick_cycle(0, 0, 0, 2, 1);
      async_reset();
      check("rst_pend", 32'(speed_pend), 32'd0);
      idle_cycles(20);

      // Randomized requests.
      for (int i = 0; i < 600; i++) begin
         tick_cycle($urandom_range(0, 7) == 0, $urandom_range(0, 14) == 0,
                    $urandom_range(0, 49) == 0, int'($urandom_range(0, 3)),
                    $urandom_range(0, 9) == 0);
         if (i == 300) async_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
